// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shifter: state encoding and datapath widths.
// Used by shift_seq and shift_step.
package shift_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/shift_step.sv
// One-bit shift step for shift_seq: left, logical right or arithmetic right.
// Rotate mode (fill with the bit shifted out) exists only when SHIFT_SEQ_ROTATE_EN is defined.
module shift_step
  import shift_pkg::*;
(
  input  data_t data,
  input  logic  lr,
  input  logic  al,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic  rot,
`endif
  output data_t next
);

  logic fill;

  // Rotate overrides the arithmetic/logical choice; al only matters for right shifts.
  always_comb begin
    fill = 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
    if (rot) begin
      fill = lr ? data[DATA_W-1] : data[0];
    end else if (!lr) begin
      fill = al ? data[DATA_W-1] : 1'b0;
    end
`else
    if (!lr) begin
      fill = al ? data[DATA_W-1] : 1'b0;
    end
`endif
  end

  always_comb begin
    next = data;
    if (lr) begin
      next = {data[DATA_W-2:0], fill};
    end else begin
      next = {fill, data[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/shift_seq.sv
// Sequential shifter: shifts an 8-bit operand one bit per clock, shamt times.
// Optional rotate mode via SHIFT_SEQ_ROTATE_EN adds the rot port.
module shift_seq
  import shift_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  input  logic [CNT_W-1:0]  shamt,
  input  logic              lr,
  input  logic              al,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic              rot,
`endif
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] dout
);

  state_t state_q, state_next;
  data_t  data_q, step_out;
  cnt_t   cnt_q;
  logic   lr_q, al_q;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic   rot_q;
`endif
  logic   accept;

  // Start is only honoured when no shift is in progress.
  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  shift_step u_step (
    .data (data_q),
    .lr   (lr_q),
    .al   (al_q),
`ifdef SHIFT_SEQ_ROTATE_EN
    .rot  (rot_q),
`endif
    .next (step_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_next = (shamt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (cnt_q == cnt_t'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_next = (shamt != '0) ? SHIFT : DONE;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Operands and mode are captured once per accepted start and frozen while shifting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= '0;
      lr_q   <= 1'b0;
      al_q   <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_q  <= 1'b0;
`endif
    end else if (accept) begin
      data_q <= din;
      cnt_q  <= shamt;
      lr_q   <= lr;
      al_q   <= al;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_q  <= rot;
`endif
    end else if (state_q == SHIFT) begin
      data_q <= step_out;
      cnt_q  <= cnt_q - cnt_t'(1);
    end
  end

  assign dout = data_q;

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-003 SHALL have port start  input  1  request pulse; sampled only in IDLE or DONE.
REQ-004 SHALL have port din  input  8  operand, captured on accepted start.
REQ-005 SHALL have port shamt  input  3  shift amount 0..7, captured on accepted start.
REQ-006 SHALL have port lr  input  1  direction: 1 = left, 0 = right.
REQ-007 SHALL have port al  input  1  right-shift fill: 1 = arithmetic (msb), 0 = logical (zero); ignored for left.
REQ-008 SHALL have port rot  input  1  rotate select; present only when SHIFT_SEQ_ROTATE_EN is defined.
REQ-009 SHALL have port busy  output  1  high while in SHIFT.
REQ-010 SHALL have port done  output  1  one-cycle pulse; high exactly while in DONE.
REQ-011 SHALL have port dout  output  8  working register; holds the result from DONE until the next accepted start.

Function
REQ-012 SHALL implement states IDLE, SHIFT and DONE.
REQ-013 SHALL accept start in IDLE or DONE: data<=din, cnt<=shamt, lr/al/rot latched; next state SHIFT if shamt!=0, else DONE.
REQ-014 SHALL, on each edge in SHIFT, apply one 1-bit shift step to data and decrement cnt; when cnt==1, next state SHALL be DONE.
REQ-015 SHALL assert done for exactly one cycle, shamt+1 cycles after the start cycle (shamt=0: the cycle immediately after start).
REQ-016 SHALL go from DONE to IDLE when start is low, and accept a back-to-back start in DONE with no idle cycle.
REQ-017 SHALL ignore start while busy; latched operands and mode SHALL remain unchanged.
REQ-018 SHALL implement the step as: left = {data[6:0],0}; right logical = {0,data[7:1]}; right arithmetic = {data[7],data[7:1]}.
REQ-019 SHALL produce a result identical to a combinational barrel shift of din by shamt with the same lr/al.
REQ-020 SHALL show intermediate values on dout during SHIFT; only the value present while done is high is the result.

Reset
REQ-021 SHALL force state=IDLE, data=0, cnt=0, busy=0, done=0 and dout=0 immediately on rst, including in the middle of a shift.
REQ-022 SHALL require a fresh start after rst deasserts; no operation in progress at reset SHALL resume.

Configuration
REQ-023 SHALL use macro SHIFT_SEQ_ROTATE_EN; when defined, rot=1 SHALL make the fill bit the bit shifted out (left fill = data[7]; right fill = data[0]), overriding al.
REQ-024 SHALL, without SHIFT_SEQ_ROTATE_EN, omit the rot port and rotate logic entirely; behaviour SHALL be as in REQ-018.

Structure
REQ-025 SHALL take the state encoding (IDLE/SHIFT/DONE), data width 8 and count width 3 from shared package shift_pkg.
REQ-026 SHALL implement the 1-bit step in combinational sub-module shift_step (inputs data, lr, al, rot; output next data); the FSM, counter and data register SHALL be in shift_seq.

Verification
REQ-027 SHALL test din=8'h96, shamt=3, lr=1 -> dout=8'hB0 with done high on the 4th cycle after start; busy high for 3 cycles.
REQ-028 SHALL test din=8'h96, shamt=2, lr=0: al=0 -> 8'h25, al=1 -> 8'hE5; also din=8'h80, shamt=7, al=1 -> 8'hFF.
REQ-029 SHALL test shamt=0, din=8'h5A -> dout=8'h5A, done on the cycle after start, busy never high.
REQ-030 SHALL test a start pulse with din=8'h00 during busy -> ignored, original result unchanged; then a back-to-back start in DONE -> accepted.
REQ-031 SHALL test rst asserted mid-shift (shamt=7, cycle 3) -> dout=0, busy=0, done=0 without waiting for a clock edge; a later start works normally.
REQ-032 SHALL test, with SHIFT_SEQ_ROTATE_EN: din=8'h81, rot=1, shamt=1: lr=0 -> 8'hC0, lr=1 -> 8'h03.
